// File: rtl/ser_add_arb_pkg.sv
// Shared types and defaults for the serial-adder sequencer/arbiter.
// The state encoding is fixed so that state dumps stay comparable across revisions.
package ser_add_arb_pkg;

    localparam int W_DEF  = 16;
    localparam int CW_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ser_add_arb_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
// The pointer (last served requester) lives in the parent so it only moves on completion.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ser_add_arb.sv
// Sequences one bit-serial adder and shares it between two requesters.
// Each operation: grant, one parallel-load cycle, W shift cycles, one done cycle.
//
// state | meaning
// IDLE  | sample req, grant a winner and latch its operands
// LOAD  | add_mode=1, adder loads add_in1/add_in2 on this edge
// SHIFT | collect add_sum LSB first, W cycles
// DONE  | publish result, pulse done to the owner, move rr pointer
module ser_add_arb
    import ser_add_arb_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         add_mode,
    output logic [W-1:0] add_in1,
    output logic [W-1:0] add_in2,
    input  logic         add_sum
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          rr_last;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  result_shift;
    logic [1:0]    arb_gnt;

    rr_arb2 u_rr_arb2 (
        .req     (req),
        .rr_last (rr_last),
        .gnt     (arb_gnt)
    );

    assign add_in1 = op_a;
    assign add_in2 = op_b;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        done      = 2'b00;
        add_mode  = 1'b0;
        case (state)
            IDLE: begin
                gnt = arb_gnt;
                if (arb_gnt != 2'b00) state_nxt = LOAD;
            end
            LOAD: begin
                add_mode  = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == CW'(W - 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = owner ? 2'b10 : 2'b01;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= 1'b0;
            rr_last      <= 1'b1;
            op_a         <= '0;
            op_b         <= '0;
            result_shift <= '0;
            result       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        owner <= arb_gnt[1];
                        op_a  <= arb_gnt[1] ? a1 : a0;
                        op_b  <= arb_gnt[1] ? b1 : b0;
                    end
                end
                LOAD: cnt <= '0;
                SHIFT: begin
                    // add_sum is LSB first, so shift in from the top
                    result_shift <= {add_sum, result_shift[W-1:1]};
                    cnt          <= cnt + CW'(1);
                end
                DONE: begin
                    result  <= result_shift;
                    rr_last <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule
